// File: rtl/regbus_pkg.sv
// Shared definitions for the register-bus SRAM window and its bus bridge:
// FSM encoding, read-latency ceiling and response codes.
package regbus_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RDWAIT = 2'd1;
  localparam logic [1:0] S_ACK    = 2'd2;

  localparam int RDLAT_MAX = 4;
  localparam int CNT_W     = $clog2(RDLAT_MAX);

  localparam logic RESP_OKAY   = 1'b0;
  localparam logic RESP_SLVERR = 1'b1;

endpackage

// File: rtl/regbus_parity.sv
// Per-byte even parity: each output bit makes its byte plus parity bit
// carry an even number of ones.
module regbus_parity #(
  parameter int DATA = 32
) (
  input  logic [DATA-1:0]   data,
  output logic [DATA/8-1:0] par
);

  always_comb begin
    par = '0;
    for (int b = 0; b < DATA/8; b++) par[b] = ^data[8*b +: 8];
  end

endmodule

// File: rtl/regbus_sram.sv
// Register-bus slave fronting a synchronous SRAM with fixed read latency.
// Optional byte parity is enabled with the REGBUS_SRAM_PARITY_EN macro.
module regbus_sram
  import regbus_pkg::*;
#(
  parameter int              ADDR  = 32,
  parameter int              DATA  = 32,
  parameter int              AW    = 10,
  parameter logic [ADDR-1:0] BASE  = '0,
  parameter int              RDLAT = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR-1:0]   addr,
  input  logic [DATA-1:0]   wdata,
  input  logic [DATA/8-1:0] wstrb,
  output logic [DATA-1:0]   rdata,
  output logic              ack,
  output logic              err,
  output logic              mem_en,
  output logic [DATA/8-1:0] mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DATA-1:0]   mem_wdata,
  input  logic [DATA-1:0]   mem_rdata
`ifdef REGBUS_SRAM_PARITY_EN
  ,
  output logic [DATA/8-1:0] mem_wpar,
  input  logic [DATA/8-1:0] mem_rpar
`endif
);

  localparam int             BL   = $clog2(DATA/8);
  localparam logic [ADDR:0]  SPAN = (ADDR+1)'(1) << (AW + BL);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA-1:0]  rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             in_range;
  logic             rd_err;

  // One extra address bit keeps the upper window bound from wrapping.
  assign in_range  = ({1'b0, addr} >= {1'b0, BASE}) &&
                     ({1'b0, addr} <  ({1'b0, BASE} + SPAN));
  assign mem_addr  = AW'((addr - BASE) >> BL);
  assign mem_wdata = wdata;

`ifdef REGBUS_SRAM_PARITY_EN
  logic [DATA/8-1:0] rpar_calc;

  regbus_parity #(.DATA(DATA)) u_wpar (
    .data (wdata),
    .par  (mem_wpar)
  );

  regbus_parity #(.DATA(DATA)) u_rpar (
    .data (mem_rdata),
    .par  (rpar_calc)
  );

  assign rd_err = |(rpar_calc ^ mem_rpar);
`else
  assign rd_err = RESP_OKAY;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = RESP_OKAY;
    mem_en  = 1'b0;
    mem_we  = '0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (!in_range) begin
            err_d   = RESP_SLVERR;
            state_d = S_ACK;
            if (!wr) rdata_d = '0;
          end else if (wr) begin
            // An all-zero strobe completes without touching the SRAM.
            mem_en  = |wstrb;
            mem_we  = wstrb;
            state_d = S_ACK;
          end else begin
            mem_en  = 1'b1;
            cnt_d   = CNT_W'(RDLAT - 1);
            state_d = S_RDWAIT;
          end
        end
      end
      S_RDWAIT: begin
        if (cnt_q == '0) begin
          rdata_d = mem_rdata;
          err_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // err_q is only ever set on the transition into ACK, so it is low otherwise.
  assign ack   = (state_q == S_ACK);
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_regbus_sram.sv
// Scoreboard bench for regbus_sram: DATA=32, BASE=0x4000, AW=10, RDLAT=3,
// with a behavioural SRAM and a word-array reference model.
module tb_regbus_sram;

  localparam int          RDLAT = 3;
  localparam int          WORDS = 1024;
  localparam logic [31:0] BASE  = 32'h4000;
  localparam logic [31:0] SPAN  = 32'h1000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef REGBUS_SRAM_PARITY_EN
  logic [3:0]  mem_wpar;
  logic [3:0]  mem_rpar;
`endif
  logic        flip_par = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_en_cnt = 0;

  typedef struct {
    bit          is_rd;
    logic        err;
    logic [31:0] rdata;
    int          ack_cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] ref_mem [WORDS];
  logic [31:0] sram    [WORDS];
  logic [3:0]  spar    [WORDS];
  logic [31:0] rpipe   [RDLAT];
  logic [3:0]  ppipe   [RDLAT];

  regbus_sram #(
    .ADDR  (32),
    .DATA  (32),
    .AW    (10),
    .BASE  (BASE),
    .RDLAT (RDLAT)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .rdata     (rdata),
    .ack       (ack),
    .err       (err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef REGBUS_SRAM_PARITY_EN
    ,
    .mem_wpar  (mem_wpar),
    .mem_rpar  (mem_rpar)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: data appears RDLAT cycles after the enable cycle.
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) begin
          sram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
`ifdef REGBUS_SRAM_PARITY_EN
          spar[mem_addr][b] = mem_wpar[b];
`endif
        end
      end
    end
    rpipe[0] <= sram[mem_addr];
    ppipe[0] <= spar[mem_addr];
    for (int i = 1; i < RDLAT; i++) begin
      rpipe[i] <= rpipe[i-1];
      ppipe[i] <= ppipe[i-1];
    end
  end
  assign mem_rdata = rpipe[RDLAT-1];
`ifdef REGBUS_SRAM_PARITY_EN
  assign mem_rpar = ppipe[RDLAT-1] ^ {2'b00, flip_par, 1'b0};
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req_v);
    end
  endtask

  // Reference model: apply the request to the word array, return what the
  // bus should see, and queue the expected completion.
  task automatic push_expect(input bit w, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] ws, output bit exp_en, output logic [3:0] exp_we,
                             output bit inr, output logic [9:0] widx);
    exp_t e;
    int   lat;
    inr    = (a >= BASE) && (a < BASE + SPAN);
    widx   = 10'((a - BASE) >> 2);
    lat    = 1;
    e.is_rd = !w;
    e.err   = !inr;
    e.rdata = '0;
    exp_en = inr && (!w || ws != 4'h0);
    exp_we = (inr && w) ? ws : 4'h0;
    if (inr && w) begin
      for (int b = 0; b < 4; b++)
        if (ws[b]) ref_mem[widx][8*b +: 8] = wd[8*b +: 8];
    end
    if (inr && !w) begin
      e.rdata = ref_mem[widx];
      lat     = RDLAT + 1;
      if (flip_par) e.err = 1'b1;
    end
    e.ack_cyc = cyc + lat;
    exp_q.push_back(e);
  endtask

  // Holds req high for n back-to-back accepted requests.
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input int n);
    bit         got;
    bit         exp_en;
    bit         inr;
    logic [3:0] exp_we;
    logic [9:0] widx;
    @(negedge clk); #1;
    req = 1'b1; wr = w; addr = a; wdata = wd; wstrb = ws;
    for (int k = 0; k < n; k++) begin
      push_expect(w, a, wd, ws, exp_en, exp_we, inr, widx);
      #1;
      check("issue_mem_en", {31'b0, mem_en}, {31'b0, exp_en});
      check("issue_mem_we", {28'b0, mem_we}, {28'b0, exp_we});
      if (inr) check("issue_mem_addr", {22'b0, mem_addr}, {22'b0, widx});
      got = 1'b0;
      for (int t = 0; t < 12 && !got; t++) begin
        @(negedge clk); #1;
        if (ack) got = 1'b1;
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL ack_timeout: ack=0 after 12 cycles, required ack=1");
      end
      if (k < n - 1) begin
        @(negedge clk); #1;
      end
    end
    req = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every ack.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (mem_en) mem_en_cnt++;
    if (ack) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack: got ack=1, required ack=0 (nothing outstanding)");
      end else begin
        e = exp_q.pop_front();
        check("ack_cycle", cyc, e.ack_cyc);
        check("ack_err", {31'b0, err}, {31'b0, e.err});
        if (e.is_rd) check("ack_rdata", rdata, e.rdata);
      end
    end else begin
      check("err_without_ack", {31'b0, err}, 32'h0);
    end
  end

  initial begin
    int          c0;
    int          sel;
    logic [31:0] a;
    for (int i = 0; i < WORDS; i++) begin
      sram[i]    = 32'hA5000000 ^ (i * 32'h00010101);
      ref_mem[i] = sram[i];
      for (int b = 0; b < 4; b++) spar[i][b] = ^sram[i][8*b +: 8];
    end

    repeat (2) @(negedge clk);
    #1;
    check("reset_ack", {31'b0, ack}, 32'h0);
    check("reset_err", {31'b0, err}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_mem_en", {31'b0, mem_en}, 32'h0);
    check("reset_mem_we", {28'b0, mem_we}, 32'h0);
    resetn = 1'b1;

    issue(1'b1, 32'h4008, 32'hDEADBEEF, 4'hF, 1);
    c0 = mem_en_cnt;
    issue(1'b0, 32'h4008, 32'h0, 4'h0, 1);
    check("read_access_count", mem_en_cnt - c0, 1);
    @(negedge clk); #1;
    check("rdata_hold", rdata, 32'hDEADBEEF);

    c0 = mem_en_cnt;
    issue(1'b0, 32'h5000, 32'h0, 4'h0, 1);
    issue(1'b1, 32'h3FFC, 32'h55AA55AA, 4'hF, 1);
    issue(1'b1, 32'h4010, 32'h12345678, 4'h0, 1);
    check("no_access_count", mem_en_cnt - c0, 0);

    issue(1'b1, 32'h4008, 32'h11223344, 4'h3, 1);
    issue(1'b0, 32'h4008, 32'h0, 4'h0, 1);
    issue(1'b0, 32'h4FFF, 32'h0, 4'h0, 1);
    issue(1'b0, 32'h3FFF, 32'h0, 4'h0, 1);

    c0 = mem_en_cnt;
    issue(1'b0, 32'h4008, 32'h0, 4'h0, 3);
    issue(1'b1, 32'h4020, 32'hCAFEF00D, 4'hC, 3);
    check("held_access_count", mem_en_cnt - c0, 6);

    // Reset while the read is waiting on the SRAM.
    @(negedge clk); #1;
    req = 1'b1; wr = 1'b0; addr = 32'h4008;
    @(negedge clk); #1;
    check("pre_reset_ack", {31'b0, ack}, 32'h0);
    resetn = 1'b0; req = 1'b0;
    #1;
    check("rst_ack", {31'b0, ack}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_en", {31'b0, mem_en}, 32'h0);
    check("rst_mem_we", {28'b0, mem_we}, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("post_reset_ack", {31'b0, ack}, 32'h0);
    issue(1'b0, 32'h4008, 32'h0, 4'h0, 1);

    repeat (60) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = BASE + SPAN + ($urandom_range(0, 63) << 2);
      else if (sel == 1) a = BASE - 32'd1 - $urandom_range(0, 255);
      else               a = BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
      issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 4) == 0) ? 2 : 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef REGBUS_SRAM_PARITY_EN
    flip_par = 1'b1;
    issue(1'b0, 32'h4008, 32'h0, 4'h0, 1);
    flip_par = 1'b0;
    issue(1'b0, 32'h4008, 32'h0, 4'h0, 1);
`endif

    repeat (3) @(negedge clk);
    #4;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
